// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio transmitter: FSM states, default geometry
// and the frame length the controller uses to pace the filter datapath.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

  localparam int unsigned DEF_CLK_DIV   = 8;
  localparam int unsigned DEF_SLOT_BITS = 32;
  localparam int unsigned DEF_DATA_BITS = 24;

  // System-clock cycles per stereo frame (1024 at the defaults).
  localparam int unsigned FRAME_CLKS = 2 * DEF_SLOT_BITS * 2 * DEF_CLK_DIV;

endpackage

// File: rtl/audio_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV system clocks while run is high,
// otherwise parks bclk low with the phase counter cleared.
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic bclk_fall,
  output logic bclk_rise
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  // Strobes lead the registered bclk edge, so users update on the same clk edge.
  assign wrap      = run && (cnt == CW'(CLK_DIV - 1));
  assign bclk_fall = wrap && bclk;
  assign bclk_rise = wrap && !bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo I2S transmitter with a one-entry sample holding register.
// Define AUDIO_I2S_TX_ROUND_EN to round-half-up (with saturation) instead of truncating.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sample_tick,
  output logic        underrun
);

  localparam int unsigned SCW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  state_e                 state;
  logic                   primed;
  logic [SCW-1:0]         slot_cnt;
  logic [SLOT_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   hold;
  logic [DATA_BITS-1:0]   frame_word;
  logic [DATA_BITS-1:0]   word_in;
  logic [DATA_BITS-1:0]   next_word;
  logic                   hold_full;
  logic                   consume;
  logic                   xfer;
  logic                   run;
  logic                   bclk_fall;
  logic                   bclk_rise_unused;
  logic                   slot_last;
  logic                   boundary;
  logic                   in_sample_unused;

  function automatic logic [SLOT_BITS-1:0] justify(input logic [DATA_BITS-1:0] w);
    justify = '0;
    justify[SLOT_BITS-1 -: DATA_BITS] = w;
  endfunction

  assign in_sample_unused = ^in_sample;

`ifdef AUDIO_I2S_TX_ROUND_EN
  if (DATA_BITS < 32) begin : g_round
    localparam logic [DATA_BITS-1:0] MAX_POS = {1'b0, {(DATA_BITS-1){1'b1}}};
    logic [DATA_BITS-1:0] trunc;
    logic                 rbit;
    assign trunc   = in_sample[31 -: DATA_BITS];
    assign rbit    = in_sample[31 - DATA_BITS];
    assign word_in = (rbit && (trunc == MAX_POS)) ? MAX_POS : trunc + DATA_BITS'(rbit);
  end else begin : g_full
    assign word_in = in_sample[31 -: DATA_BITS];
  end
`else
  assign word_in = in_sample[31 -: DATA_BITS];
`endif

  assign in_ready  = !hold_full;
  assign xfer      = in_valid && !hold_full;
  assign run       = (state != ST_IDLE) || (en && hold_full);
  assign slot_last = (slot_cnt == SCW'(SLOT_BITS - 1));
  assign next_word = hold_full ? hold : frame_word;

  // The first fall after leaving IDLE is itself the frame boundary, hence 'primed'.
  assign boundary = bclk_fall &&
                    (((state == ST_LEFT) && primed) ||
                     ((state == ST_RIGHT) && slot_last && en));

  audio_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .bclk     (bclk),
    .bclk_fall(bclk_fall),
    .bclk_rise(bclk_rise_unused)
  );

  // Release of the holding register lags the boundary by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      consume   <= 1'b0;
    end else begin
      consume <= boundary && hold_full;
      if (xfer) begin
        hold      <= word_in;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      primed      <= 1'b0;
      slot_cnt    <= '0;
      shreg       <= '0;
      frame_word  <= '0;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= boundary;
      underrun    <= boundary && !hold_full;
      if (boundary) begin
        // frame_word doubles as the replay word when the holding register is empty.
        frame_word <= next_word;
        shreg      <= justify(next_word);
        sdata      <= shreg[SLOT_BITS-1];
        slot_cnt   <= '0;
        lrclk      <= 1'b0;
        primed     <= 1'b0;
        state      <= ST_LEFT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en && hold_full) begin
              state  <= ST_LEFT;
              primed <= 1'b1;
            end
          end
          ST_LEFT: begin
            if (bclk_fall) begin
              sdata <= shreg[SLOT_BITS-1];
              if (slot_last) begin
                state    <= ST_RIGHT;
                lrclk    <= 1'b1;
                slot_cnt <= '0;
                shreg    <= justify(frame_word);
              end else begin
                slot_cnt <= slot_cnt + SCW'(1);
                shreg    <= shreg << 1;
              end
            end
          end
          ST_RIGHT: begin
            if (bclk_fall) begin
              if (slot_last) begin
                state    <= ST_IDLE;
                lrclk    <= 1'b1;
                sdata    <= 1'b0;
                slot_cnt <= '0;
                shreg    <= '0;
              end else begin
                sdata    <= shreg[SLOT_BITS-1];
                slot_cnt <= slot_cnt + SCW'(1);
                shreg    <= shreg << 1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
